// File: rtl/mxdiv_stage_sequencer.sv
// mxdiv_stage_sequencer: top-level phase sequencer for the matrix divider.
// Launches NUM_STAGES sub-unit controllers in order. Each unit gets a one-cycle
// start pulse, and the next unit launches only after the current unit reports
// done. A watchdog bounds the time spent waiting on any single unit. A single
// done pulse marks the end of the whole division.
// Optional build macro STAGE_SKIP_EN adds the skip_mask input. skip_mask is
// latched when a start is accepted, and masked stages are bypassed.
module mxdiv_stage_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int TIMEOUT    = 64,
  parameter int IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_STAGES-1:0] stage_done,
`ifdef STAGE_SKIP_EN
  input  logic [NUM_STAGES-1:0] skip_mask,
`endif
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [IDX_W-1:0]      stage_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [NUM_STAGES-1:0]   stage_start_q, stage_start_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  // Skip-mask plumbing: mask seen at start acceptance, and the mask held for the run.
  logic [NUM_STAGES-1:0]   accept_mask;
  logic [NUM_STAGES-1:0]   mask_q;
  logic                    start_accept;

  // Search results: {found, index} of the first runnable stage at/after a position.
  logic [IDX_W:0]          first_stage;
  logic [IDX_W:0]          next_stage;
  logic                    cur_done;

  // Lowest-numbered unmasked stage whose index is >= from. MSB flags "found".
  function automatic logic [IDX_W:0] find_next(input logic [IDX_W:0]      from,
                                               input logic [NUM_STAGES-1:0] mask);
    logic [IDX_W:0] r;
    r = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if ((k >= int'(from)) && !mask[k]) begin
        r = {1'b1, IDX_W'(k)};
      end
    end
    return r;
  endfunction

  // A start is only honoured when no run is in flight.
  assign start_accept = start &&
                        ((state_q == S_IDLE) || (state_q == S_FINISH) || (state_q == S_ERROR));

`ifdef STAGE_SKIP_EN
  assign accept_mask = skip_mask;

  // Capture the skip mask for the run when a start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
    end else if (start_accept) begin
      mask_q <= skip_mask;
    end
  end
`else
  assign accept_mask = '0;
  assign mask_q      = '0;
`endif

  // Next-state, watchdog and registered-output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    first_stage = find_next('0, accept_mask);
    next_stage  = find_next({1'b0, idx_q} + 1'b1, mask_q);
    cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Only the done level of the stage being awaited matters.
    cur_done = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_done = stage_done[k];
      end
    end

    case (state_q)
      S_IDLE, S_FINISH, S_ERROR: begin
        if (start) begin
          // With every stage masked, the run goes straight to FINISH.
          idx_d   = first_stage[IDX_W-1:0];
          cnt_d   = '0;
          state_d = first_stage[IDX_W] ? S_LAUNCH : S_FINISH;
        end else if (state_q == S_FINISH) begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        // Done is deliberately ignored here so a stale level cannot retire the stage.
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (cur_done) begin
          // Done takes priority over a watchdog expiry in the same cycle.
          if (next_stage[IDX_W]) begin
            idx_d   = next_stage[IDX_W-1:0];
            cnt_d   = '0;
            state_d = S_LAUNCH;
          end else begin
            state_d = S_FINISH;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    stage_start_d = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if ((state_d == S_LAUNCH) && (idx_d == IDX_W'(k))) begin
        stage_start_d[k] = 1'b1;
      end
    end
    busy_d = (state_d == S_LAUNCH) || (state_d == S_WAIT);
    done_d = (state_d == S_FINISH);
    // ERROR is left only through an accepted start, so err is sticky until then.
    err_d  = (state_d == S_ERROR);
  end

  // State, index, watchdog and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      stage_start_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign stage_start = stage_start_q;
  assign stage_idx   = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mxdiv_stage_sequencer.sv
// Scoreboard bench for mxdiv_stage_sequencer.
// A plan task turns each run's per-stage response delays into an expected
// timeline of launch/done/error events using plain cycle arithmetic. A
// responder emulates the sub-units, and a monitor pops and compares events.
module tb_mxdiv_stage_sequencer;
  localparam int N  = 4;
  localparam int TO = 64;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  stage_done = '0;
  logic [N-1:0]  mask_drv = '0;
  logic [N-1:0]  stage_start;
  logic [IW-1:0] stage_idx;
  logic          busy, done, err;

  mxdiv_stage_sequencer #(.NUM_STAGES(N), .TIMEOUT(TO), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stage_done (stage_done),
`ifdef STAGE_SKIP_EN
    .skip_mask  (mask_drv),
`endif
    .stage_start(stage_start),
    .stage_idx  (stage_idx),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = launch, 1 = done, 2 = error; val = expected stage_idx
  typedef struct {int t; int kind; int val;} ev_t;
  ev_t exp_q[$];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   dly[N]   = '{default: 2};
  int   deadline[N] = '{default: -1};
  bit   hold_all = 1'b0;
  bit   mon_en   = 1'b0;
  logic err_prev = 1'b0;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected timeline: launch at s+1; each stage's done after d cycles gives the next launch d+1 later.
  task automatic plan(input int s, output int end_t);
    int t;
    int last;
    t     = s + 1;
    last  = 0;
    end_t = -1;
    for (int i = 0; i < N; i++) begin
      if (!mask_drv[i]) begin
        exp_q.push_back('{t, 0, i});
        last = i;
        if (dly[i] > TO - 1) begin
          exp_q.push_back('{t + TO, 2, i});
          end_t = t + TO;
          return;
        end
        t = t + dly[i] + 1;
      end
    end
    exp_q.push_back('{t, 1, last});
    end_t = t;
  endtask

  task automatic start_run(output int end_t);
    plan(cyc, end_t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Sub-unit emulation: done rises dly cycles after the launch and stays high until relaunched.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        stage_done[i] = 1'b0;
        deadline[i]   = -1;
      end else if (hold_all) begin
        stage_done[i] = 1'b1;
      end else if (stage_start[i]) begin
        stage_done[i] = 1'b0;
        deadline[i]   = (dly[i] < TO) ? cyc + dly[i] : -1;
      end else if (deadline[i] == cyc) begin
        stage_done[i] = 1'b1;
      end
    end
  end

  task automatic check_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", 1'b0, kind, -1);
      return;
    end
    e = exp_q.pop_front();
    chk("event_cycle", cyc == e.t, cyc, e.t);
    chk("event_kind", kind == e.kind, kind, e.kind);
    chk("event_stage_idx", int'(stage_idx) == e.val, int'(stage_idx), e.val);
    if (kind == 0) begin
      chk("launch_onehot", stage_start == N'(1 << e.val), int'(stage_start), 1 << e.val);
      chk("launch_busy", busy == 1'b1, int'(busy), 1);
      chk("launch_err_clear", err == 1'b0, int'(err), 0);
    end else begin
      chk("end_busy_low", busy == 1'b0, int'(busy), 0);
      chk("end_no_launch", stage_start == '0, int'(stage_start), 0);
    end
  endtask

  // Monitor: every observed output event is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      err_prev = err;
    end else begin
      if (|stage_start) check_event(0);
      if (done) check_event(1);
      if (err && !err_prev) check_event(2);
      err_prev = err;
      while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
        chk("missing_event_at", 1'b0, cyc, exp_q[0].t);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int e;
    int cur;
    int g;

    repeat (3) @(negedge clk);
    chk("rst_stage_start", stage_start == '0, int'(stage_start), 0);
    chk("rst_stage_idx", stage_idx == '0, int'(stage_idx), 0);
    chk("rst_busy", busy == 1'b0, int'(busy), 0);
    chk("rst_done", done == 1'b0, int'(done), 0);
    chk("rst_err", err == 1'b0, int'(err), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    $display("reset released at cycle %0d", cyc);

    // Nominal: each unit answers 3 cycles after its launch.
    dly = '{3, 3, 3, 3};
    start_run(e);
    wait_cyc(e + 2);
    $display("nominal run done, expected done at %0d", e);

    // Stale and foreign done levels held high on every bit.
    hold_all = 1'b1;
    dly = '{default: 1};
    start_run(e);
    wait_cyc(e);
    hold_all = 1'b0;
    wait_cyc(e + 2);
    $display("held-done run, expected done at %0d", e);

    // Done on the last cycle before the watchdog expires still wins.
    dly = '{1, TO - 1, 1, 1};
    start_run(e);
    wait_cyc(e + 1);
    $display("watchdog boundary run, expected done at %0d", e);

    // Stage 2 hangs.
    dly = '{2, 5, 1000, 3};
    start_run(e);
    wait_cyc(e + 3);
    chk("err_sticky", err == 1'b1, int'(err), 1);
    chk("err_stage_idx", stage_idx == IW'(2), int'(stage_idx), 2);
    chk("err_busy", busy == 1'b0, int'(busy), 0);
    $display("watchdog run, expected err at %0d", e);

    // Recovery from ERROR, a start pulse during WAIT, then back-to-back start in FINISH.
    dly = '{4, 3, 3, 3};
    start_run(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(e);
    dly = '{2, 2, 2, 2};
    start_run(e);
    wait_cyc(e + 2);
    $display("recovery and back-to-back runs, expected done at %0d", e);

    // Reset in the WAIT of stage 1.
    dly = '{4, 6, 4, 4};
    start_run(e);
    cur = cyc;
    wait_cyc(cur + 7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_stage_start", stage_start == '0, int'(stage_start), 0);
    chk("async_rst_stage_idx", stage_idx == '0, int'(stage_idx), 0);
    chk("async_rst_busy", busy == 1'b0, int'(busy), 0);
    chk("async_rst_err", err == 1'b0, int'(err), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_idle_busy", busy == 1'b0, int'(busy), 0);
    $display("mid-run reset checked at cycle %0d", cyc);
    dly = '{2, 3, 2, 3};
    start_run(e);
    wait_cyc(e + 1);

`ifdef STAGE_SKIP_EN
    // Masked stages are bypassed; all-masked goes straight to FINISH.
    dly = '{2, 2, 2, 2};
    mask_drv = 4'b0101;
    start_run(e);
    wait_cyc(e + 1);
    mask_drv = 4'b1111;
    start_run(e);
    wait_cyc(e + 1);
    mask_drv = '0;
    $display("skip-mask runs complete");
`endif

    // Randomized runs with random gaps, including back-to-back and occasional hangs.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 10);
      if ($urandom_range(0, 5) == 0) dly[$urandom_range(0, N - 1)] = 1000;
`ifdef STAGE_SKIP_EN
      mask_drv = N'($urandom);
`endif
      start_run(e);
      wait_cyc(e + $urandom_range(0, 3));
      $display("random run %0d: delays %0d %0d %0d %0d, expected end at %0d",
               r, dly[0], dly[1], dly[2], dly[3], e);
    end

    g = 0;
    while (exp_q.size() > 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
